// File: rtl/dm_lsu_if.sv
// Request/response and data-memory bus of the load/store initiator.
// master = CPU side plus memory model, slave = dm_lsu.
interface dm_lsu_if #(parameter int ADDR_W = 12);
  logic              req_valid;
  logic              req_ready;
  logic [2:0]        req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              resp_valid;
  logic [31:0]       resp_rdata;
  logic              resp_err;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_din;
  logic              mem_we;
  logic [1:0]        mem_mode;
  logic [31:0]       mem_dout;

  modport master (
    output req_valid, req_op, req_addr, req_wdata, mem_dout,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_addr, mem_din, mem_we, mem_mode
  );
  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, mem_dout,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_addr, mem_din, mem_we, mem_mode
  );
endinterface

// File: rtl/dm_lsu.sv
// Load/store initiator: one request at a time, word-only memory cycles,
// lane extract/extend on loads and read-modify-write for SB/SH.
module dm_lsu #(
  parameter int ADDR_W       = 12,
  parameter bit MISALIGN_ERR = 1'b1
) (
  input  logic     clk,
  input  logic     RST,
  dm_lsu_if.slave  bus
);
  localparam logic [2:0] OP_LW = 3'd0, OP_LH = 3'd1, OP_LHU = 3'd2, OP_LB = 3'd3,
                         OP_LBU = 3'd4, OP_SW = 3'd5, OP_SH = 3'd6, OP_SB = 3'd7;
  localparam int NUM_LANES = 4;

  typedef enum logic [2:0] {IDLE, RD, EXT, WR, RESP} state_t;

  state_t            state;
  logic [2:0]        op_q;
  logic [ADDR_W-1:0] addr_q;
  logic [31:0]       wdata_q;
  logic [31:0]       merge_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [31:0]       rdata_q;
  logic              err_q;

  // Alignment check and forced alignment on the incoming request
  logic              is_word, is_half, misal;
  logic [ADDR_W-1:0] acc_addr;
  always_comb begin
    is_word  = (bus.req_op == OP_LW) || (bus.req_op == OP_SW);
    is_half  = (bus.req_op == OP_LH) || (bus.req_op == OP_LHU) || (bus.req_op == OP_SH);
    misal    = (is_word && (bus.req_addr[1:0] != 2'b00)) || (is_half && bus.req_addr[0]);
    acc_addr = bus.req_addr;
    if (is_word)      acc_addr[1:0] = 2'b00;
    else if (is_half) acc_addr[0]   = 1'b0;
  end

  // Load lane extraction and extension
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] ld_ext;
  always_comb begin
    case (addr_q[1:0])
      2'd0:    lane_b = bus.mem_dout[7:0];
      2'd1:    lane_b = bus.mem_dout[15:8];
      2'd2:    lane_b = bus.mem_dout[23:16];
      default: lane_b = bus.mem_dout[31:24];
    endcase
    lane_h = addr_q[1] ? bus.mem_dout[31:16] : bus.mem_dout[15:0];
    case (op_q)
      OP_LH:   ld_ext = {{16{lane_h[15]}}, lane_h};
      OP_LHU:  ld_ext = {16'h0, lane_h};
      OP_LB:   ld_ext = {{24{lane_b[7]}}, lane_b};
      OP_LBU:  ld_ext = {24'h0, lane_b};
      default: ld_ext = bus.mem_dout;
    endcase
  end

  // Store merge: selected lanes take new data, the rest keep the old word
  logic [NUM_LANES-1:0] lane_sel;
  logic [31:0]          merged;
  always_comb begin
    lane_sel = '0;
    if (op_q == OP_SB)      lane_sel = 4'b0001 << addr_q[1:0];
    else if (op_q == OP_SH) lane_sel = addr_q[1] ? 4'b1100 : 4'b0011;
  end
  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    logic [7:0] nb;
    assign nb = (op_q == OP_SB) ? wdata_q[7:0] : wdata_q[8*(k%2) +: 8];
    assign merged[8*k +: 8] = lane_sel[k] ? nb : bus.mem_dout[8*k +: 8];
  end

  always_ff @(posedge clk or negedge RST) begin
    if (!RST) begin
      state      <= IDLE;
      op_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      merge_q    <= '0;
      mem_addr_q <= '0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (bus.req_valid) begin
          op_q    <= bus.req_op;
          addr_q  <= acc_addr;
          wdata_q <= bus.req_wdata;
          if (MISALIGN_ERR && misal) begin
            rdata_q <= '0;
            err_q   <= 1'b1;
            state   <= RESP;
          end else begin
            mem_addr_q <= {bus.req_addr[ADDR_W-1:2], 2'b00};
            state      <= (bus.req_op == OP_SW) ? WR : RD;
          end
        end
        RD:  state <= EXT;
        EXT: if (op_q >= OP_SW) begin
          merge_q <= merged;
          state   <= WR;
        end else begin
          rdata_q <= ld_ext;
          err_q   <= 1'b0;
          state   <= RESP;
        end
        WR: begin
          rdata_q <= '0;
          err_q   <= 1'b0;
          state   <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Outputs decode only from registered state
  assign bus.req_ready  = RST && (state == IDLE);
  assign bus.resp_valid = (state == RESP);
  assign bus.resp_rdata = rdata_q;
  assign bus.resp_err   = err_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_din    = (op_q == OP_SW) ? wdata_q : merge_q;
  assign bus.mem_we     = (state == WR);
  assign bus.mem_mode   = 2'b00;
endmodule

// File: tb/tb_dm_lsu.sv
// Directed bench for dm_lsu: one instance with misalignment errors, one with
// forced alignment, each backed by a word memory with registered read.
module tb_dm_lsu;
  localparam int AW = 12;
  localparam logic [2:0] LW = 3'd0, LH = 3'd1, LHU = 3'd2, LB = 3'd3,
                         LBU = 3'd4, SW = 3'd5, SH = 3'd6, SB = 3'd7;

  logic clk = 1'b0;
  logic RST = 1'b0;
  always #5 clk = ~clk;

  dm_lsu_if #(.ADDR_W(AW)) b0 ();
  dm_lsu_if #(.ADDR_W(AW)) b1 ();

  dm_lsu #(.ADDR_W(AW), .MISALIGN_ERR(1'b1)) dut0 (.clk(clk), .RST(RST), .bus(b0));
  dm_lsu #(.ADDR_W(AW), .MISALIGN_ERR(1'b0)) dut1 (.clk(clk), .RST(RST), .bus(b1));

  logic [31:0] mem0 [1024];
  logic [31:0] mem1 [1024];
  always @(posedge clk) begin
    if (b0.mem_we) mem0[b0.mem_addr[AW-1:2]] <= b0.mem_din;
    else           b0.mem_dout <= mem0[b0.mem_addr[AW-1:2]];
    if (b1.mem_we) mem1[b1.mem_addr[AW-1:2]] <= b1.mem_din;
    else           b1.mem_dout <= mem1[b1.mem_addr[AW-1:2]];
  end

  int          we_pulses = 0;
  logic [31:0] last_din = '0;
  logic [AW-1:0] last_waddr = '0;
  logic        mode_bad = 1'b0;
  always @(negedge clk) begin
    if (b0.mem_we) begin
      we_pulses  <= we_pulses + 1;
      last_din   <= b0.mem_din;
      last_waddr <= b0.mem_addr;
    end
    if (b0.mem_mode !== 2'b00 || b1.mem_mode !== 2'b00) mode_bad <= 1'b1;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input bit w, input logic v, input logic [2:0] op,
                       input logic [AW-1:0] a, input logic [31:0] wd);
    if (w) begin
      b1.req_valid = v; b1.req_op = op; b1.req_addr = a; b1.req_wdata = wd;
    end else begin
      b0.req_valid = v; b0.req_op = op; b0.req_addr = a; b0.req_wdata = wd;
    end
  endtask

  // One request: lat = edges from the accept edge (inclusive) to entering RESP
  task automatic xact(input bit w, input logic [2:0] op, input logic [AW-1:0] a,
                      input logic [31:0] wd, output logic [31:0] rd,
                      output logic er, output int lat);
    int n;
    @(negedge clk);
    drive(w, 1'b1, op, a, wd);
    n = 0;
    while (!(w ? b1.req_ready : b0.req_ready) && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    drive(w, 1'b0, op, a, wd);
    lat = 1;
    while (!(w ? b1.resp_valid : b0.resp_valid) && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rd = w ? b1.resp_rdata : b0.resp_rdata;
    er = w ? b1.resp_err : b0.resp_err;
    #1;
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat, wp, acc, rsp;

  initial begin
    drive(1'b0, 1'b0, LW, '0, '0);
    drive(1'b1, 1'b0, LW, '0, '0);

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_ready",  {31'b0, b0.req_ready},  32'd0);
    chk("rst_rvalid", {31'b0, b0.resp_valid}, 32'd0);
    chk("rst_we",     {31'b0, b0.mem_we},     32'd0);
    chk("rst_maddr",  {20'b0, b0.mem_addr},   32'd0);
    chk("rst_mdin",   b0.mem_din,             32'd0);
    RST = 1'b1;
    #1;
    chk("rel_ready", {31'b0, b0.req_ready}, 32'd1);

    // SW then LW
    wp = we_pulses;
    xact(1'b0, SW, 12'h010, 32'hDEADBEEF, rd, er, lat);
    chk("sw_lat",    lat, 2);
    chk("sw_pulses", we_pulses - wp, 1);
    chk("sw_din",    last_din, 32'hDEADBEEF);
    chk("sw_waddr",  {20'b0, last_waddr}, 32'h010);
    chk("sw_rdata",  rd, 32'd0);
    xact(1'b0, LW, 12'h010, '0, rd, er, lat);
    chk("lw_rdata", rd, 32'hDEADBEEF);
    chk("lw_lat",   lat, 3);
    chk("lw_err",   {31'b0, er}, 32'd0);

    // Sub-word loads
    xact(1'b0, SW, 12'h020, 32'h80FF7F01, rd, er, lat);
    xact(1'b0, LB,  12'h023, '0, rd, er, lat);  chk("lb_023",  rd, 32'hFFFFFF80);
    xact(1'b0, LBU, 12'h023, '0, rd, er, lat);  chk("lbu_023", rd, 32'h00000080);
    xact(1'b0, LB,  12'h020, '0, rd, er, lat);  chk("lb_020",  rd, 32'h00000001);
    xact(1'b0, LH,  12'h022, '0, rd, er, lat);  chk("lh_022",  rd, 32'hFFFF80FF);
    xact(1'b0, LHU, 12'h022, '0, rd, er, lat);  chk("lhu_022", rd, 32'h000080FF);
    chk("lhu_lat", lat, 3);

    // Read-modify-write
    xact(1'b0, SW, 12'h030, 32'h11223344, rd, er, lat);
    wp = we_pulses;
    xact(1'b0, SB, 12'h031, 32'h000000AB, rd, er, lat);
    chk("sb_lat",    lat, 4);
    chk("sb_pulses", we_pulses - wp, 1);
    chk("sb_din",    last_din, 32'h1122AB44);
    xact(1'b0, SH, 12'h032, 32'h0000CDEF, rd, er, lat);
    chk("sh_din", last_din, 32'hCDEFAB44);
    xact(1'b0, LW, 12'h030, '0, rd, er, lat);
    chk("rmw_word", rd, 32'hCDEFAB44);

    // Misalignment errors
    wp = we_pulses;
    xact(1'b0, LW, 12'h013, '0, rd, er, lat);
    chk("mis_lw_err", {31'b0, er}, 32'd1);
    chk("mis_lw_rd",  rd, 32'd0);
    chk("mis_lw_lat", lat, 1);
    xact(1'b0, SH, 12'h015, 32'h1234, rd, er, lat);
    chk("mis_sh_err", {31'b0, er}, 32'd1);
    chk("mis_sh_lat", lat, 1);
    chk("mis_no_we",  we_pulses - wp, 0);

    // Forced alignment
    xact(1'b1, SW, 12'h010, 32'h13572468, rd, er, lat);
    xact(1'b1, LW, 12'h013, '0, rd, er, lat);
    chk("aln_lw_rd",  rd, 32'h13572468);
    chk("aln_lw_err", {31'b0, er}, 32'd0);

    // req_valid held high: accepts only when ready, one response each
    acc = 0; rsp = 0;
    @(negedge clk);
    drive(1'b0, 1'b1, LB, 12'h023, '0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (b0.req_ready) acc++;
      if (b0.resp_valid) rsp++;
    end
    drive(1'b0, 1'b0, LB, 12'h023, '0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (b0.resp_valid) rsp++;
    end
    chk("hs_acc",   acc, 4);
    chk("hs_rsp",   rsp, 4);
    chk("hs_rdata", b0.resp_rdata, 32'hFFFFFF80);

    // Reset during WR: write must not happen
    xact(1'b0, SW, 12'h040, 32'h01020304, rd, er, lat);
    @(negedge clk);
    drive(1'b0, 1'b1, SW, 12'h040, 32'h99999999);
    @(negedge clk);
    chk("wr_we_hi", {31'b0, b0.mem_we}, 32'd1);
    drive(1'b0, 1'b0, SW, 12'h040, 32'h99999999);
    #2 RST = 1'b0;
    #1;
    chk("mid_we",     {31'b0, b0.mem_we},     32'd0);
    chk("mid_ready",  {31'b0, b0.req_ready},  32'd0);
    chk("mid_rvalid", {31'b0, b0.resp_valid}, 32'd0);
    chk("mid_rdata",  b0.resp_rdata,          32'd0);
    chk("mid_maddr",  {20'b0, b0.mem_addr},   32'd0);
    @(negedge clk);
    RST = 1'b1;
    #1;
    chk("mid_rel_ready", {31'b0, b0.req_ready}, 32'd1);
    rsp = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (b0.resp_valid) rsp++;
    end
    chk("mid_no_resp", rsp, 0);
    xact(1'b0, LW, 12'h040, '0, rd, er, lat);
    chk("mid_no_write", rd, 32'h01020304);

    chk("mode_word", {31'b0, mode_bad}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
